// File: rtl/csr_file.sv
// Machine-mode CSR file: trap/interrupt state, mtvec/mepc/mscratch,
// level-sensitive interrupt sampling and 64-bit cycle/instret counters.
module csr_file #(
    parameter int NUM_IRQ      = 4,
    parameter int HAS_COUNTERS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_ill,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               int_taken,
    input  logic               int_ret,
    input  logic               instr_ret,
    input  logic [31:0]        next_pc,
    output logic [31:0]        mepc,
    output logic [31:0]        mtvec,
    output logic               int_pending,
    output logic [4:0]         int_cause
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam bit CNT_EN = (HAS_COUNTERS != 0);

    logic               st_mie;
    logic               st_mpie;
    logic [NUM_IRQ-1:0] mie_q;
    logic [NUM_IRQ-1:0] mip_q;
    logic [31:2]        mtvec_q;
    logic [31:2]        mepc_q;
    logic [31:0]        mscratch_q;
    logic [31:0]        mcause_q;
    logic [63:0]        mcycle_q;
    logic [63:0]        minstret_q;

    logic [31:0]        mie_rd;
    logic [31:0]        mip_rd;
    logic [31:0]        wval;
    logic               impl;
    logic               ro;
    logic               wr;
    logic [NUM_IRQ-1:0] hit;

    // next_pc is word-aligned on trap entry; its low bits never matter
    logic unused_ok;
    assign unused_ok = &{1'b0, next_pc[1:0]};

    assign mie_rd = {16'(mie_q), 16'h0};
    assign mip_rd = {16'(mip_q), 16'h0};
    assign mtvec  = {mtvec_q, 2'b00};
    assign mepc   = {mepc_q, 2'b00};

    always_comb begin
        csr_rdata = '0;
        impl      = 1'b1;
        ro        = 1'b0;
        case (csr_addr)
            A_MSTATUS:   csr_rdata = {24'h0, st_mpie, 3'b000,
                                      st_mie, 3'b000};
            A_MIE:       csr_rdata = mie_rd;
            A_MTVEC:     csr_rdata = mtvec;
            A_MSCRATCH:  csr_rdata = mscratch_q;
            A_MEPC:      csr_rdata = mepc;
            A_MCAUSE:    csr_rdata = mcause_q;
            A_MIP: begin
                csr_rdata = mip_rd;
                ro        = 1'b1;
            end
            A_MCYCLE:    csr_rdata = CNT_EN ? mcycle_q[31:0] : '0;
            A_MCYCLEH:   csr_rdata = CNT_EN ? mcycle_q[63:32] : '0;
            A_MINSTRET:  csr_rdata = CNT_EN ? minstret_q[31:0] : '0;
            A_MINSTRETH: csr_rdata = CNT_EN ? minstret_q[63:32] : '0;
            default:     impl = 1'b0;
        endcase
    end

    assign csr_ill = !impl || (ro && csr_op != 2'b00);
    assign wr      = impl && !ro && csr_op != 2'b00;

    always_comb begin
        unique case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc;
    logic we_mcause, we_cyc, we_cych, we_ins, we_insh;

    assign we_mstatus  = wr && csr_addr == A_MSTATUS;
    assign we_mie      = wr && csr_addr == A_MIE;
    assign we_mtvec    = wr && csr_addr == A_MTVEC;
    assign we_mscratch = wr && csr_addr == A_MSCRATCH;
    assign we_mepc     = wr && csr_addr == A_MEPC;
    assign we_mcause   = wr && csr_addr == A_MCAUSE;
    assign we_cyc      = CNT_EN && wr && csr_addr == A_MCYCLE;
    assign we_cych     = CNT_EN && wr && csr_addr == A_MCYCLEH;
    assign we_ins      = CNT_EN && wr && csr_addr == A_MINSTRET;
    assign we_insh     = CNT_EN && wr && csr_addr == A_MINSTRETH;

    // Lowest enabled pending line wins
    assign hit = mip_q & mie_q;

    always_comb begin
        int_cause = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (hit[i]) int_cause = 5'(16 + i);
        end
    end

    assign int_pending = st_mie && |hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mscratch_q <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mip_q <= irq;
            if (int_taken) begin
                mepc_q   <= next_pc[31:2];
                mcause_q <= {1'b1, 26'h0, int_cause};
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else begin
                if (int_ret) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end else if (we_mstatus) begin
                    st_mie  <= wval[3];
                    st_mpie <= wval[7];
                end
                if (we_mepc)   mepc_q   <= wval[31:2];
                if (we_mcause) mcause_q <= wval;
            end
            if (we_mie)      mie_q      <= wval[16 +: NUM_IRQ];
            if (we_mtvec)    mtvec_q    <= wval[31:2];
            if (we_mscratch) mscratch_q <= wval;

            // A write to either half freezes the counter for that edge
            if (we_cyc)
                mcycle_q[31:0] <= wval;
            else if (we_cych)
                mcycle_q[63:32] <= wval;
            else if (CNT_EN)
                mcycle_q <= mcycle_q + 64'd1;

            if (we_ins)
                minstret_q[31:0] <= wval;
            else if (we_insh)
                minstret_q[63:32] <= wval;
            else if (CNT_EN && instr_ret)
                minstret_q <= minstret_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: CSR ops, traps,
// interrupts, counters, illegal accesses and reset behaviour.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_ill;
    logic [3:0]  irq;
    logic        int_taken;
    logic        int_ret;
    logic        instr_ret;
    logic [31:0] next_pc;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic        int_pending;
    logic [4:0]  int_cause;

    int passed = 0;
    int total  = 0;

    csr_file #(.NUM_IRQ(4), .HAS_COUNTERS(1)) dut (
        .clk(clk), .rst(rst),
        .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_ill(csr_ill), .irq(irq),
        .int_taken(int_taken), .int_ret(int_ret),
        .instr_ret(instr_ret), .next_pc(next_pc),
        .mepc(mepc), .mtvec(mtvec),
        .int_pending(int_pending), .int_cause(int_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_do(input logic [1:0] op,
                          input logic [11:0] addr,
                          input logic [31:0] data);
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_op    = 2'b00;
        csr_wdata = '0;
    endtask

    task automatic peek(input logic [11:0] addr);
        csr_addr = addr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        peek(12'h300);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_mstatus got %h exp %h", csr_rdata, 32'h0);
        else passed++;
        total++;
        if (mepc !== 32'h0 || mtvec !== 32'h0)
            $display("FAIL rst_vec got %h/%h exp 0/0", mepc, mtvec);
        else passed++;
        total++;
        if (int_pending !== 1'b0)
            $display("FAIL rst_pend got %b exp 0", int_pending);
        else passed++;
        peek(12'hB00);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_mcycle got %h exp 0", csr_rdata);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_rw_ops();
        csr_do(2'b01, 12'h305, 32'h0000_1003);
        peek(12'h305);
        total++;
        if (mtvec !== 32'h0000_1000 || csr_rdata !== 32'h0000_1000)
            $display("FAIL mtvec_rw got %h/%h exp 00001000",
                     mtvec, csr_rdata);
        else passed++;
        csr_do(2'b10, 12'h305, 32'h0000_0003);
        total++;
        if (mtvec !== 32'h0000_1000)
            $display("FAIL mtvec_rs got %h exp 00001000", mtvec);
        else passed++;
        csr_do(2'b01, 12'h341, 32'h0000_0047);
        total++;
        if (mepc !== 32'h0000_0044)
            $display("FAIL mepc_rw got %h exp 00000044", mepc);
        else passed++;
        csr_do(2'b01, 12'h340, 32'hA5A5_0F0F);
        csr_op    = 2'b10;
        csr_addr  = 12'h340;
        csr_wdata = 32'h0000_F0F0;
        #1;
        total++;
        if (csr_rdata !== 32'hA5A5_0F0F)
            $display("FAIL scr_old got %h exp a5a50f0f", csr_rdata);
        else passed++;
        tick();
        csr_op = 2'b00;
        peek(12'h340);
        total++;
        if (csr_rdata !== 32'hA5A5_FFFF)
            $display("FAIL scr_rs got %h exp a5a5ffff", csr_rdata);
        else passed++;
        csr_do(2'b11, 12'h340, 32'hFFFF_0000);
        peek(12'h340);
        total++;
        if (csr_rdata !== 32'h0000_FFFF)
            $display("FAIL scr_rc got %h exp 0000ffff", csr_rdata);
        else passed++;
    endtask

    task automatic test_mie();
        csr_do(2'b01, 12'h304, 32'h0);
        csr_do(2'b10, 12'h304, 32'h0003_0000);
        csr_do(2'b11, 12'h304, 32'h0001_0000);
        peek(12'h304);
        total++;
        if (csr_rdata !== 32'h0002_0000)
            $display("FAIL mie_rsrc got %h exp 00020000", csr_rdata);
        else passed++;
        csr_do(2'b01, 12'h304, 32'hFFFF_FFFF);
        peek(12'h304);
        total++;
        if (csr_rdata !== 32'h000F_0000)
            $display("FAIL mie_mask got %h exp 000f0000", csr_rdata);
        else passed++;
    endtask

    task automatic test_irq_trap();
        csr_do(2'b01, 12'h300, 32'h8);
        csr_do(2'b01, 12'h304, 32'h0002_0000);
        irq = 4'b0010;
        #1;
        total++;
        if (int_pending !== 1'b0)
            $display("FAIL irq_lat got %b exp 0", int_pending);
        else passed++;
        tick();
        total++;
        if (int_pending !== 1'b1 || int_cause !== 5'd17)
            $display("FAIL irq_pend got %b/%0d exp 1/17",
                     int_pending, int_cause);
        else passed++;
        peek(12'h344);
        total++;
        if (csr_rdata !== 32'h0002_0000)
            $display("FAIL mip_rd got %h exp 00020000", csr_rdata);
        else passed++;
        int_taken = 1'b1;
        next_pc   = 32'h44;
        tick();
        int_taken = 1'b0;
        total++;
        if (mepc !== 32'h44)
            $display("FAIL trap_mepc got %h exp 00000044", mepc);
        else passed++;
        peek(12'h342);
        total++;
        if (csr_rdata !== 32'h8000_0011)
            $display("FAIL trap_cause got %h exp 80000011", csr_rdata);
        else passed++;
        peek(12'h300);
        total++;
        if (csr_rdata !== 32'h80 || int_pending !== 1'b0)
            $display("FAIL trap_mst got %h/%b exp 80/0",
                     csr_rdata, int_pending);
        else passed++;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        peek(12'h300);
        total++;
        if (csr_rdata !== 32'h88 || int_pending !== 1'b1)
            $display("FAIL mret_mst got %h/%b exp 88/1",
                     csr_rdata, int_pending);
        else passed++;
        int_taken = 1'b1;
        int_ret   = 1'b1;
        next_pc   = 32'h103;
        tick();
        int_taken = 1'b0;
        int_ret   = 1'b0;
        peek(12'h300);
        total++;
        if (csr_rdata !== 32'h80 || mepc !== 32'h100)
            $display("FAIL both_mst got %h/%h exp 80/00000100",
                     csr_rdata, mepc);
        else passed++;
        int_ret   = 1'b1;
        csr_do(2'b01, 12'h300, 32'h0);
        int_ret   = 1'b0;
        peek(12'h300);
        total++;
        if (csr_rdata !== 32'h88)
            $display("FAIL ret_vs_csr got %h exp 88", csr_rdata);
        else passed++;
        irq = 4'b1010;
        csr_do(2'b01, 12'h304, 32'h000A_0000);
        total++;
        if (int_cause !== 5'd17)
            $display("FAIL cause_low got %0d exp 17", int_cause);
        else passed++;
        csr_do(2'b01, 12'h304, 32'h0008_0000);
        total++;
        if (int_cause !== 5'd19)
            $display("FAIL cause_19 got %0d exp 19", int_cause);
        else passed++;
        irq = 4'b0000;
        csr_do(2'b01, 12'h304, 32'h0);
        csr_do(2'b01, 12'h300, 32'h0);
        total++;
        if (int_cause !== 5'd0 || int_pending !== 1'b0)
            $display("FAIL cause_none got %0d/%b exp 0/0",
                     int_cause, int_pending);
        else passed++;
    endtask

    task automatic test_counters();
        csr_do(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr_do(2'b01, 12'hB80, 32'h0);
        peek(12'hB00);
        total++;
        if (csr_rdata !== 32'hFFFF_FFFF)
            $display("FAIL cyc_hold got %h exp ffffffff", csr_rdata);
        else passed++;
        tick();
        tick();
        peek(12'hB80);
        total++;
        if (csr_rdata !== 32'h1)
            $display("FAIL cyc_hi got %h exp 00000001", csr_rdata);
        else passed++;
        peek(12'hB00);
        total++;
        if (csr_rdata !== 32'h1)
            $display("FAIL cyc_lo got %h exp 00000001", csr_rdata);
        else passed++;
        instr_ret = 1'b0;
        csr_do(2'b01, 12'hB02, 32'h5);
        tick();
        tick();
        instr_ret = 1'b1;
        tick();
        tick();
        tick();
        instr_ret = 1'b0;
        peek(12'hB02);
        total++;
        if (csr_rdata !== 32'h8)
            $display("FAIL ins_cnt got %h exp 00000008", csr_rdata);
        else passed++;
        instr_ret = 1'b1;
        csr_do(2'b01, 12'hB02, 32'hA);
        instr_ret = 1'b0;
        peek(12'hB02);
        total++;
        if (csr_rdata !== 32'hA)
            $display("FAIL ins_wr got %h exp 0000000a", csr_rdata);
        else passed++;
        peek(12'hB82);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL ins_hi got %h exp 0", csr_rdata);
        else passed++;
    endtask

    task automatic test_illegal();
        irq = 4'b0001;
        tick();
        csr_op    = 2'b11;
        csr_addr  = 12'h344;
        csr_wdata = 32'hFFFF_FFFF;
        #1;
        total++;
        if (csr_ill !== 1'b1)
            $display("FAIL mip_wr_ill got %b exp 1", csr_ill);
        else passed++;
        tick();
        csr_op = 2'b00;
        peek(12'h344);
        total++;
        if (csr_rdata !== 32'h0001_0000 || csr_ill !== 1'b0)
            $display("FAIL mip_keep got %h/%b exp 00010000/0",
                     csr_rdata, csr_ill);
        else passed++;
        peek(12'h7FF);
        total++;
        if (csr_ill !== 1'b1 || csr_rdata !== 32'h0)
            $display("FAIL unimpl got %b/%h exp 1/0", csr_ill, csr_rdata);
        else passed++;
        csr_do(2'b01, 12'h7FF, 32'h1234_5678);
        peek(12'h340);
        total++;
        if (csr_rdata !== 32'h0000_FFFF || csr_ill !== 1'b0)
            $display("FAIL unimpl_nochg got %h/%b exp 0000ffff/0",
                     csr_rdata, csr_ill);
        else passed++;
        irq = 4'b0000;
    endtask

    task automatic test_reset_mid_trap();
        csr_do(2'b01, 12'h300, 32'h8);
        csr_do(2'b01, 12'h304, 32'h0002_0000);
        csr_do(2'b01, 12'h305, 32'h200);
        irq = 4'b0010;
        tick();
        total++;
        if (int_pending !== 1'b1)
            $display("FAIL pre_rst got %b exp 1", int_pending);
        else passed++;
        rst       = 1'b1;
        int_taken = 1'b1;
        next_pc   = 32'h80;
        csr_op    = 2'b01;
        csr_addr  = 12'h340;
        csr_wdata = 32'hDEAD_BEEF;
        tick();
        csr_op = 2'b00;
        total++;
        if (mepc !== 32'h0 || mtvec !== 32'h0 || int_pending !== 1'b0)
            $display("FAIL rst_trap got %h/%h/%b exp 0/0/0",
                     mepc, mtvec, int_pending);
        else passed++;
        peek(12'h342);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_cause got %h exp 0", csr_rdata);
        else passed++;
        peek(12'h300);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_mst2 got %h exp 0", csr_rdata);
        else passed++;
        peek(12'h340);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_scr got %h exp 0", csr_rdata);
        else passed++;
        peek(12'h304);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_mie got %h exp 0", csr_rdata);
        else passed++;
        peek(12'h344);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_mip got %h exp 0", csr_rdata);
        else passed++;
        peek(12'hB02);
        total++;
        if (csr_rdata !== 32'h0)
            $display("FAIL rst_ins got %h exp 0", csr_rdata);
        else passed++;
        int_taken = 1'b0;
        irq       = 4'b0000;
        rst       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        csr_addr  = '0;
        csr_op    = 2'b00;
        csr_wdata = '0;
        irq       = '0;
        int_taken = 1'b0;
        int_ret   = 1'b0;
        instr_ret = 1'b0;
        next_pc   = '0;
        test_reset();
        test_rw_ops();
        test_mie();
        test_irq_trap();
        test_counters();
        test_illegal();
        test_reset_mid_trap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter NUM_IRQ, default 4, range 1..16: number of external interrupt lines.
REQ-002 Parameter HAS_COUNTERS, default 1: 1 = mcycle/minstret implemented, 0 = those addresses read 0 and ignore writes.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port csr_addr  input  12  CSR address.
REQ-006 Port csr_op  input  2  00 none, 01 write (RW), 10 set (RS), 11 clear (RC).
REQ-007 Port csr_wdata  input  32  operand for csr_op.
REQ-008 Port csr_rdata  output  32  current (pre-update) value at csr_addr, combinational.
REQ-009 Port csr_ill  output  1  combinational; 1 when csr_addr is unimplemented, or csr_op != 00 to a read-only CSR.
REQ-010 Port irq  input  NUM_IRQ  level-sensitive external interrupt requests.
REQ-011 Port int_taken  input  1  core commits trap entry this cycle.
REQ-012 Port int_ret  input  1  core commits mret this cycle.
REQ-013 Port instr_ret  input  1  one instruction retired this cycle.
REQ-014 Port next_pc  input  32  return address captured on trap entry.
REQ-015 Port mepc  output  32  current mepc.
REQ-016 Port mtvec  output  32  current mtvec.
REQ-017 Port int_pending  output  1  mstatus.MIE AND any(mip AND mie), combinational from registers.
REQ-018 Port int_cause  output  5  16 + lowest index i with mip[i] AND mie[16+i]; 0 when none.

Function
REQ-019 Implemented CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304 (bits 16..16+NUM_IRQ-1 writable, others 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
REQ-020 New value for RW = wdata, RS = old OR wdata, RC = old AND NOT wdata; updated on next rising edge; csr_rdata in the op cycle shows old value.
REQ-021 Unimplemented address: csr_rdata 0, no state change; csr_ill 1 regardless of csr_op.
REQ-022 mtvec and mepc bits [1:0] are hardwired 0 on every write path.
REQ-023 mip bit 16+i = irq[i] sampled through one register stage (1-cycle latency), writes ignored.
REQ-024 Trap entry (int_taken): mepc <= next_pc[31:2],2'b00; mcause <= {1'b1, 26'b0, int_cause}; MPIE <= MIE; MIE <= 0.
REQ-025 mret (int_ret): MIE <= MPIE; MPIE <= 1.
REQ-026 Priority per cycle: int_taken > int_ret > CSR op for any field they both touch; non-overlapping fields update independently.
REQ-027 int_taken and int_ret together: int_ret ignored.
REQ-028 mcycle: 64-bit, +1 every cycle not in reset; minstret: 64-bit, +1 when instr_ret; both wrap 2^64-1 -> 0.
REQ-029 CSR write to either half of a counter in a cycle replaces that half; the counter does not increment that cycle (other half unchanged).
REQ-030 Low-half carry into high half occurs in the same edge as the wrap of the low half.

Reset
REQ-031 On rst: mstatus, mie, mtvec, mscratch, mepc, mcause, mip register, mcycle, minstret all 0; mepc/mtvec outputs 0; int_pending 0.
REQ-032 rst overrides int_taken, int_ret, CSR op and counter increment in the same cycle.

Verification
REQ-033 RW 0x305 with 0x0000_1003 -> next cycle mtvec = 0x0000_1000, csr_rdata at 0x305 = 0x0000_1000.
REQ-034 mstatus = 0x8, mie = 0x0002_0000, irq[1]=1 -> int_pending 1 after one cycle, int_cause 17; int_taken with next_pc 0x44 -> mepc 0x44, mcause 0x8000_0011, mstatus 0x80.
REQ-035 int_ret after REQ-034 -> mstatus 0x88; simultaneous int_taken+int_ret -> only trap entry effects.
REQ-036 RS 0x304 with 0x0003_0000 then RC with 0x0001_0000 -> mie 0x0002_0000 (NUM_IRQ >= 2).
REQ-037 Write mcycle = 0xFFFF_FFFF, mcycleh = 0 -> two edges later mcycleh = 1, mcycle = 0x0000_0001; mip write and address 0x7FF -> csr_ill 1, no change.
REQ-038 Assert rst mid-trap (int_taken same cycle) -> all CSRs 0 next cycle, int_pending 0.
